uart_tx: RTL and testbench

- 8N1-style UART transmitter that sits directly downstream of the baud tick generator.
- Consumes the one-cycle `tick` pulse, which fires once per bit period, and serialises bytes onto the `tx` line.
- Has a small input FIFO with a valid/ready handshake, so the host can queue several bytes and have them sent back-to-back with no idle gaps.

---
 rtl/uart_tx.sv | 166 ++++++++++++++++
 tb/tb_uart_tx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1-style serialiser fed by a small valid/ready FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bits.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic                 push;
  logic                 pop;
  logic                 empty;
  logic [DATA_BITS-1:0] head;

  logic [2:0]           state;
  logic [DATA_BITS-1:0] shift;
  logic [BW-1:0]        bit_idx;
  logic                 stop_cnt;
  logic                 last_stop;
`ifdef UART_TX_PARITY_EN
  logic                 par;
`endif

  assign empty      = (count == '0);
  assign tx_ready   = (count != (AW+1)'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign head       = mem[rd_ptr];
  assign fifo_count = count;
  assign busy       = (state != IDLE);
  assign last_stop  = (stop_cnt == 1'(STOP_BITS-1));

  // Pop on the tick that starts a frame, whether from idle or back-to-back.
  assign pop = tick && !empty &&
               ((state == IDLE) || ((state == STOP) && last_stop));

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (!empty) begin
              shift <= head;
`ifdef UART_TX_PARITY_EN
              par   <= ^head;
`endif
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx <= 1'b1;
            end
          end
          START: begin
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end
          DATA: begin
            if (bit_idx != BW'(DATA_BITS-1)) begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end else begin
`ifdef UART_TX_PARITY_EN
              tx       <= par;
              state    <= PARITY;
`else
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
`endif
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
`endif
          STOP: begin
            if (!last_stop) begin
              stop_cnt <= 1'b1;
            end else begin
              tx_done <= 1'b1;
              if (!empty) begin
                shift <= head;
`ifdef UART_TX_PARITY_EN
                par   <= ^head;
`endif
                tx    <= 1'b0;
                state <= START;
              end else begin
                tx    <= 1'b1;
                state <= IDLE;
              end
            end
          end
          default: begin
            tx    <= 1'b1;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: random and directed stimulus against a bit-queue
// line model of the transmitter.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int DEPTH = 4;
  localparam int FRAME = 16 * (10 + PB);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  uart_tx #(
    .DATA_BITS (8),
    .FIFO_DEPTH(DEPTH),
    .STOP_BITS (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int tick_mode = 1;
  int tcnt = 0;

  // model: queued bytes, and the line bits still owed by the current frame
  logic [7:0] mq[$];
  bit         bq[$];
  bit         inframe = 1'b0;
  bit         m_tx = 1'b1;
  bit         m_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_frame(input logic [7:0] b);
    bq.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      bq.push_back(b[i]);
    if (PB == 1)
      bq.push_back(^b);
    bq.push_back(1'b1);
  endtask

  task automatic model_step();
    int n0;
    if (rst) begin
      mq.delete();
      bq.delete();
      inframe = 1'b0;
      m_tx    = 1'b1;
      m_done  = 1'b0;
      return;
    end
    n0     = mq.size();
    m_done = 1'b0;
    if (tick) begin
      if (bq.size() == 0) begin
        if (inframe) begin
          m_done  = 1'b1;
          inframe = 1'b0;
        end
        if (mq.size() > 0) begin
          load_frame(mq.pop_front());
          inframe = 1'b1;
        end
      end
      m_tx = (bq.size() > 0) ? bq.pop_front() : 1'b1;
    end
    if (tx_valid && n0 < DEPTH)
      mq.push_back(tx_data);
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    tcnt = (tcnt + 1) % 16;
    case (tick_mode)
      0:       tick = 1'b0;
      1:       tick = (tcnt == 0);
      2:       tick = 1'b1;
      default: tick = ($urandom_range(3) == 0);
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("tx", tx, m_tx);
      chk("busy", busy, inframe);
      chk("tx_done", tx_done, m_done);
      chk("fifo_count", fifo_count, mq.size());
      chk("tx_ready", tx_ready, mq.size() < DEPTH);
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    tx_valid = v;
    tx_data  = d;
  endtask

  task automatic capture(output logic [7:0] d, output logic p,
                         output logic sb, output logic eb,
                         output int ts);
    int k;
    k = 0;
    p = 1'b0;
    do begin
      @(negedge clk);
      k++;
    end while (tx !== 1'b0 && k < 3000);
    chk("start_timeout", k >= 3000, 0);
    ts = cyc;
    repeat (8) @(negedge clk);
    sb = tx;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      d[i] = tx;
    end
    if (PB == 1) begin
      repeat (16) @(negedge clk);
      p = tx;
    end
    repeat (16) @(negedge clk);
    eb = tx;
  endtask

  task automatic wait_done(output int t);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (tx_done !== 1'b1 && k < 3000);
    chk("done_timeout", k >= 3000, 0);
    t = cyc;
  endtask

  logic [7:0] d;
  logic       p, sb, eb;
  int         ts, t1, t2, k;

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_count", fifo_count, 0);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);

    // single byte
    drive(1'b1, 8'h55);
    drive(1'b0, 8'h00);
    capture(d, p, sb, eb, ts);
    chk("s_start", sb, 0);
    chk("s_data", d, 8'h55);
    chk("s_stop", eb, 1);
    wait_done(t1);
    chk("s_len", t1 - ts, FRAME);
    chk("s_busy", busy, 0);
    chk("s_line", tx, 1);
    repeat (40) @(negedge clk);

    // back-to-back
    drive(1'b1, 8'hA5);
    drive(1'b1, 8'h3C);
    drive(1'b0, 8'h00);
    capture(d, p, sb, eb, ts);
    chk("b1_data", d, 8'hA5);
    wait_done(t1);
    chk("b2_start_now", tx, 0);
    capture(d, p, sb, eb, ts);
    chk("b2_data", d, 8'h3C);
    chk("b2_stop", eb, 1);
    wait_done(t2);
    chk("b2b_gap", t2 - t1, FRAME);
    repeat (40) @(negedge clk);

    // FIFO full
    tick_mode = 0;
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 5; i++)
      drive(1'b1, 8'(i));
    drive(1'b0, 8'h00);
    chk("full_count", fifo_count, 4);
    chk("full_ready", tx_ready, 0);
    tick_mode = 1;
    for (int i = 1; i <= 4; i++) begin
      capture(d, p, sb, eb, ts);
      chk("full_order", d, i);
    end
    wait_done(t1);
    repeat (40) @(negedge clk);

    // reset mid-frame
    drive(1'b1, 8'hC3);
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h22);
    drive(1'b0, 8'h00);
    k = 0;
    while (tx !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("mr_start_timeout", k >= 100, 0);
    repeat (56) @(negedge clk);
    chk("mr_queued", fifo_count, 2);
    #2 rst = 1'b1;
    #1;
    chk("mr_tx", tx, 1);
    chk("mr_busy", busy, 0);
    chk("mr_count", fifo_count, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("mr_idle_line", tx, 1);
    chk("mr_idle_busy", busy, 0);

`ifdef UART_TX_PARITY_EN
    drive(1'b1, 8'h07);
    drive(1'b0, 8'h00);
    capture(d, p, sb, eb, ts);
    chk("p7_data", d, 8'h07);
    chk("p7_par", p, 1);
    chk("p7_stop", eb, 1);
    wait_done(t1);
    chk("p7_len", t1 - ts, 176);
    repeat (20) @(negedge clk);
    drive(1'b1, 8'h03);
    drive(1'b0, 8'h00);
    capture(d, p, sb, eb, ts);
    chk("p3_data", d, 8'h03);
    chk("p3_par", p, 0);
    wait_done(t1);
    repeat (20) @(negedge clk);
`endif

    // random traffic across tick modes
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0)
        tick_mode = $urandom_range(3);
      drive($urandom_range(3) == 0, 8'($urandom));
    end
    drive(1'b0, 8'h00);
    tick_mode = 2;
    k = 0;
    while ((mq.size() != 0 || inframe) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", k >= 2000, 0);
    repeat (10) @(negedge clk);
    chk("end_line", tx, 1);
    chk("end_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
